mp_reg_file: RTL and testbench
==============================

MP_REG_FILE -- requirements
Module: mp_reg_file

Interface
REQ-001 SHALL take parameter XLEN, default 64, data width in bits.
REQ-002 SHALL take parameter NREG, default 32, register count (power of two, >=2); AW = log2(NREG).
REQ-003 SHALL take parameter NRD, default 2, read port count (1..4).
REQ-004 SHALL take parameter NWR, default 2, write port count (1..2).
REQ-005 SHALL have port clk  input  1  rising-edge clock.
REQ-006 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-007 SHALL have port i_wen  input  NWR  per-port write enable.
REQ-008 SHALL have port i_waddr  input  NWR*AW  flattened write addresses, port k at bits [k*AW +: AW].
REQ-009 SHALL have port i_wdata  input  NWR*XLEN  flattened write data.
REQ-010 SHALL have port i_ren  input  NRD  per-port read enable.
REQ-011 SHALL have port i_raddr  input  NRD*AW  flattened read addresses.
REQ-012 SHALL have port o_rdata  output  NRD*XLEN  flattened read data.
REQ-013 SHALL have port o_rbusy  output  NRD  read register has pending producer.
REQ-014 SHALL have port i_alloc_en  input  1  mark destination busy (issue).
REQ-015 SHALL have port i_alloc_addr  input  AW  destination being allocated.
REQ-016 SHALL have port i_flush  input  1  clear all busy bits.
REQ-017 SHALL have port o_busy_vec  output  NREG  current scoreboard state.

Function
REQ-018 Register 0 SHALL read as zero, never be written, never be busy.
REQ-019 Writes SHALL update storage on the clk rising edge where i_wen[k]=1 and address non-zero.
REQ-020 Same-cycle writes to one address SHALL resolve with the highest-numbered port winning.
REQ-021 Reads SHALL be combinational, zero latency.
REQ-022 Read with i_ren[j]=0 SHALL return zero data and o_rbusy[j]=0.
REQ-023 Read matching an active same-cycle write SHALL bypass that write's data (highest port wins), not stored data.
REQ-024 Busy bit SHALL set on clk edge when i_alloc_en=1 and i_alloc_addr non-zero.
REQ-025 Busy bit SHALL clear on clk edge when any enabled write targets that address.
REQ-026 Simultaneous write-clear and alloc on the same address SHALL leave the bit set.
REQ-027 i_flush SHALL clear all busy bits and override alloc in the same cycle; storage unaffected.
REQ-028 o_rbusy[j] SHALL be busy_vec[addr] AND NOT (same-cycle write to addr); zero for address 0.
REQ-029 Alloc of an already-busy address SHALL keep it busy (no counting).

Reset
REQ-030 On rst_n=0 at a clk edge, all registers SHALL become zero and all busy bits clear.
REQ-031 During reset, o_rdata SHALL still follow REQ-021..023 combinationally; writes and allocs that cycle are discarded.
REQ-032 o_busy_vec SHALL read zero the cycle after reset; reset mid-operation SHALL abandon pending producers.

Structure
REQ-033 Shared package rf_pkg SHALL hold XLEN/NREG defaults, AW function, and zero-register constant.
REQ-034 Scoreboard SHALL be a sub-module rf_scoreboard (busy vector, set/clear/flush logic, o_rbusy lookup).
REQ-035 Storage and bypass mux SHALL reside in mp_reg_file; no latches, all reads from flop array.

Verification
REQ-036 Reset, then read all addresses -> every o_rdata = 0, o_busy_vec = 0.
REQ-037 Write x5=0xDEAD_BEEF port 0, read x5 same cycle -> bypassed 0xDEAD_BEEF; next cycle stored value same.
REQ-038 Ports 0 and 1 write x7 with 0x11 and 0x22 -> x7 = 0x22 afterwards; same-cycle read returns 0x22.
REQ-039 Write x0=0xFFFF -> x0 reads 0; alloc x0 -> o_busy_vec[0] stays 0.
REQ-040 Alloc x3, next cycle read x3 -> o_rbusy=1; write x3 with alloc x3 same cycle -> busy stays 1, read that cycle o_rbusy=0.
REQ-041 Alloc x4, x9 over two cycles, then i_flush with alloc x6 -> o_busy_vec = 0; data registers unchanged.

Source files
------------

// File: rtl/rf_pkg.sv
// Shared defaults and helpers for the multi-port register file and its scoreboard.
package rf_pkg;
  localparam int XLEN_DEF = 64;
  localparam int NREG_DEF = 32;
  localparam int ZERO_REG = 0;

  function automatic int aw_of(input int nreg);
    return (nreg > 1) ? $clog2(nreg) : 1;
  endfunction
endpackage

// File: rtl/rf_scoreboard.sv
// Busy-bit scoreboard: tracks registers with an outstanding producer.
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int NREG = NREG_DEF,
  parameter int NRD  = 2,
  parameter int NWR  = 2,
  localparam int AW  = aw_of(NREG)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NWR-1:0]      i_wen,
  input  logic [NWR*AW-1:0]   i_waddr,
  input  logic [NRD-1:0]      i_ren,
  input  logic [NRD*AW-1:0]   i_raddr,
  input  logic                i_alloc_en,
  input  logic [AW-1:0]       i_alloc_addr,
  input  logic                i_flush,
  output logic [NRD-1:0]      o_rbusy,
  output logic [NREG-1:0]     o_busy_vec
);

  logic [NREG-1:0] busy_r;
  logic [NREG-1:0] busy_nxt_s;
  logic [NRD-1:0]  rbusy_s;
  logic [AW-1:0]   wa_s;
  logic [AW-1:0]   ra_s;
  logic            hit_s;

  // Next busy state: writes retire producers, alloc wins over a same-cycle retire, flush wins over all.
  always_comb begin
    busy_nxt_s = busy_r;
    wa_s       = {AW{1'b0}};
    if (i_flush) begin
      busy_nxt_s = {NREG{1'b0}};
    end else begin
      for (int k = 0; k < NWR; k++) begin
        wa_s = i_waddr[k*AW +: AW];
        busy_nxt_s[wa_s] = i_wen[k] ? 1'b0 : busy_nxt_s[wa_s];
      end
      busy_nxt_s[i_alloc_addr] = (i_alloc_en && (i_alloc_addr != AW'(ZERO_REG)))
                                 ? 1'b1 : busy_nxt_s[i_alloc_addr];
    end
    busy_nxt_s[ZERO_REG] = 1'b0;
  end

  // Busy vector register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy_r <= {NREG{1'b0}};
    end else begin
      busy_r <= busy_nxt_s;
    end
  end

  // Read-port busy lookup; a same-cycle write to the address means the value is already here.
  always_comb begin
    rbusy_s = {NRD{1'b0}};
    ra_s    = {AW{1'b0}};
    hit_s   = 1'b0;
    for (int j = 0; j < NRD; j++) begin
      ra_s  = i_raddr[j*AW +: AW];
      hit_s = 1'b0;
      for (int k = 0; k < NWR; k++) begin
        hit_s = hit_s | (i_wen[k] && (i_waddr[k*AW +: AW] == ra_s));
      end
      rbusy_s[j] = i_ren[j] && (ra_s != AW'(ZERO_REG)) && busy_r[ra_s] && !hit_s;
    end
  end

  assign o_rbusy    = rbusy_s;
  assign o_busy_vec = busy_r;

endmodule

// File: rtl/mp_reg_file.sv
// Multi-port integer register file with write-to-read bypass and producer scoreboard.
module mp_reg_file
  import rf_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int NREG = NREG_DEF,
  parameter int NRD  = 2,
  parameter int NWR  = 2,
  localparam int AW  = aw_of(NREG)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NWR-1:0]      i_wen,
  input  logic [NWR*AW-1:0]   i_waddr,
  input  logic [NWR*XLEN-1:0] i_wdata,
  input  logic [NRD-1:0]      i_ren,
  input  logic [NRD*AW-1:0]   i_raddr,
  output logic [NRD*XLEN-1:0] o_rdata,
  output logic [NRD-1:0]      o_rbusy,
  input  logic                i_alloc_en,
  input  logic [AW-1:0]       i_alloc_addr,
  input  logic                i_flush,
  output logic [NREG-1:0]     o_busy_vec
);

  logic [XLEN-1:0]     regs_r [NREG];
  logic [NRD*XLEN-1:0] rdata_s;
  logic [AW-1:0]       ra_s;
  logic [XLEN-1:0]     val_s;

  // Storage update; ascending port order lets the highest enabled port win a same-address collision.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        regs_r[i] <= {XLEN{1'b0}};
      end
    end else begin
      for (int k = 0; k < NWR; k++) begin
        if (i_wen[k] && (i_waddr[k*AW +: AW] != AW'(ZERO_REG))) begin
          regs_r[i_waddr[k*AW +: AW]] <= i_wdata[k*XLEN +: XLEN];
        end
      end
    end
  end

  // Combinational read with bypass from same-cycle writes; x0 and disabled ports read zero.
  always_comb begin
    rdata_s = {(NRD*XLEN){1'b0}};
    ra_s    = {AW{1'b0}};
    val_s   = {XLEN{1'b0}};
    for (int j = 0; j < NRD; j++) begin
      ra_s  = i_raddr[j*AW +: AW];
      val_s = regs_r[ra_s];
      for (int k = 0; k < NWR; k++) begin
        val_s = (i_wen[k] && (i_waddr[k*AW +: AW] == ra_s)) ? i_wdata[k*XLEN +: XLEN] : val_s;
      end
      if (i_ren[j] && (ra_s != AW'(ZERO_REG))) begin
        rdata_s[j*XLEN +: XLEN] = val_s;
      end else begin
        rdata_s[j*XLEN +: XLEN] = {XLEN{1'b0}};
      end
    end
  end

  assign o_rdata = rdata_s;

  rf_scoreboard #(
    .NREG (NREG),
    .NRD  (NRD),
    .NWR  (NWR)
  ) u_scoreboard (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_wen        (i_wen),
    .i_waddr      (i_waddr),
    .i_ren        (i_ren),
    .i_raddr      (i_raddr),
    .i_alloc_en   (i_alloc_en),
    .i_alloc_addr (i_alloc_addr),
    .i_flush      (i_flush),
    .o_rbusy      (o_rbusy),
    .o_busy_vec   (o_busy_vec)
  );

endmodule

// File: tb/tb_mp_reg_file.sv
// Randomized bench for mp_reg_file against an array-based model, plus directed scenarios.
module tb_mp_reg_file;
  localparam int XLEN = 64;
  localparam int NREG = 32;
  localparam int AW   = 5;
  localparam int NRD  = 2;
  localparam int NWR  = 2;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [NWR-1:0]      wen;
  logic [NWR*AW-1:0]   waddr;
  logic [NWR*XLEN-1:0] wdata;
  logic [NRD-1:0]      ren;
  logic [NRD*AW-1:0]   raddr;
  logic [NRD*XLEN-1:0] rdata;
  logic [NRD-1:0]      rbusy;
  logic                alloc_en;
  logic [AW-1:0]       alloc_addr;
  logic                flush;
  logic [NREG-1:0]     busy_vec;

  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 1'b0;

  logic [XLEN-1:0] mregs [NREG];
  logic [NREG-1:0] mbusy;

  mp_reg_file #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .NWR(NWR)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_wen        (wen),
    .i_waddr      (waddr),
    .i_wdata      (wdata),
    .i_ren        (ren),
    .i_raddr      (raddr),
    .o_rdata      (rdata),
    .o_rbusy      (rbusy),
    .i_alloc_en   (alloc_en),
    .i_alloc_addr (alloc_addr),
    .i_flush      (flush),
    .o_busy_vec   (busy_vec)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  function automatic int wa(input int k);
    return int'(waddr[k*AW +: AW]);
  endfunction

  function automatic int ra(input int j);
    return int'(raddr[j*AW +: AW]);
  endfunction

  // Read value: disabled port or x0 gives zero; otherwise the highest-numbered matching write, else storage.
  function automatic logic [63:0] exp_rdata(input int j);
    logic [63:0] v;
    if (!ren[j] || ra(j) == 0) return 64'd0;
    v = mregs[ra(j)];
    for (int k = 0; k < NWR; k++)
      if (wen[k] && wa(k) == ra(j)) v = wdata[k*XLEN +: XLEN];
    return v;
  endfunction

  function automatic logic exp_rbusy(input int j);
    bit written = 1'b0;
    if (!ren[j] || ra(j) == 0) return 1'b0;
    for (int k = 0; k < NWR; k++)
      if (wen[k] && wa(k) == ra(j)) written = 1'b1;
    return mbusy[ra(j)] && !written;
  endfunction

  function automatic logic [NREG-1:0] next_busy();
    logic [NREG-1:0] nb = mbusy;
    if (flush) return '0;
    for (int k = 0; k < NWR; k++)
      if (wen[k]) nb[wa(k)] = 1'b0;
    if (alloc_en && alloc_addr != 0) nb[alloc_addr] = 1'b1;
    nb[0] = 1'b0;
    return nb;
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) mregs[i] <= '0;
      mbusy <= '0;
    end else begin
      for (int k = 0; k < NWR; k++)
        if (wen[k] && wa(k) != 0) mregs[wa(k)] <= wdata[k*XLEN +: XLEN];
      mbusy <= next_busy();
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int j = 0; j < NRD; j++) begin
        chk("model_rdata", rdata[j*XLEN +: XLEN], exp_rdata(j));
        chk("model_rbusy", {63'd0, rbusy[j]}, {63'd0, exp_rbusy(j)});
      end
      chk("model_busy_vec", {32'd0, busy_vec}, {32'd0, mbusy});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wen = '0; waddr = '0; wdata = '0; ren = '0; raddr = '0;
    alloc_en = 1'b0; alloc_addr = '0; flush = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    tick();
    chk_en = 1'b1;
    wen = 2'b11; waddr = {5'd5, 5'd9}; wdata = {64'hAAAA, 64'hBBBB};
    alloc_en = 1'b1; alloc_addr = 5'd9;
    tick();
    idle();
    rst_n = 1'b1;

    // Reset state over all addresses
    for (int a = 0; a < NREG; a++) begin
      ren = 2'b11; raddr = {5'(a), 5'(a)};
      @(negedge clk);
      chk("reset_rdata0", rdata[63:0], 64'd0);
      chk("reset_rdata1", rdata[127:64], 64'd0);
      chk("reset_busy_vec", {32'd0, busy_vec}, 64'd0);
      tick();
    end

    // Bypass then stored value
    idle();
    wen = 2'b01; waddr = {5'd0, 5'd5}; wdata = {64'd0, 64'hDEAD_BEEF};
    ren = 2'b01; raddr = {5'd0, 5'd5};
    @(negedge clk); chk("bypass_x5", rdata[63:0], 64'hDEAD_BEEF);
    tick(); wen = 2'b00;
    @(negedge clk); chk("stored_x5", rdata[63:0], 64'hDEAD_BEEF);
    tick();

    // Same-address double write: port 1 wins
    idle();
    wen = 2'b11; waddr = {5'd7, 5'd7}; wdata = {64'h22, 64'h11};
    ren = 2'b10; raddr = {5'd7, 5'd0};
    @(negedge clk); chk("collide_bypass_x7", rdata[127:64], 64'h22);
    tick(); wen = 2'b00;
    @(negedge clk); chk("collide_stored_x7", rdata[127:64], 64'h22);
    tick();

    // x0 is never written or busy
    idle();
    wen = 2'b01; waddr = '0; wdata = {64'd0, 64'hFFFF};
    ren = 2'b01; raddr = '0; alloc_en = 1'b1; alloc_addr = 5'd0;
    @(negedge clk); chk("x0_bypass", rdata[63:0], 64'd0);
    tick(); wen = 2'b00; alloc_en = 1'b0;
    @(negedge clk);
    chk("x0_stored", rdata[63:0], 64'd0);
    chk("x0_busy", {63'd0, busy_vec[0]}, 64'd0);
    tick();

    // Alloc then write+alloc on the same register
    idle();
    alloc_en = 1'b1; alloc_addr = 5'd3;
    tick();
    alloc_en = 1'b0; ren = 2'b01; raddr = {5'd0, 5'd3};
    @(negedge clk); chk("x3_rbusy", {63'd0, rbusy[0]}, 64'd1);
    tick();
    wen = 2'b01; waddr = {5'd0, 5'd3}; wdata = {64'd0, 64'h33};
    alloc_en = 1'b1; alloc_addr = 5'd3;
    @(negedge clk); chk("x3_rbusy_write", {63'd0, rbusy[0]}, 64'd0);
    tick();
    wen = 2'b00; alloc_en = 1'b0;
    @(negedge clk);
    chk("x3_busy_kept", {63'd0, busy_vec[3]}, 64'd1);
    chk("x3_data", rdata[63:0], 64'h33);
    tick();

    // Flush overrides alloc; storage intact
    idle();
    alloc_en = 1'b1; alloc_addr = 5'd4; tick();
    alloc_addr = 5'd9; tick();
    @(negedge clk); chk("pre_flush_busy", {32'd0, busy_vec}, 64'h0000_0218);
    flush = 1'b1; alloc_addr = 5'd6; tick();
    idle(); ren = 2'b11; raddr = {5'd7, 5'd5};
    @(negedge clk);
    chk("flush_busy_vec", {32'd0, busy_vec}, 64'd0);
    chk("flush_x5", rdata[63:0], 64'hDEAD_BEEF);
    chk("flush_x7", rdata[127:64], 64'h22);
    tick();

    // Randomized traffic, narrow address window half the time to force collisions
    for (int n = 0; n < 3000; n++) begin
      automatic bit narrow = $urandom_range(0, 1) == 1;
      rst_n = ($urandom_range(0, 99) != 0);
      wen = 2'($urandom);
      ren = 2'($urandom);
      for (int k = 0; k < 2; k++) begin
        waddr[k*AW +: AW] = narrow ? 5'($urandom_range(0, 7)) : 5'($urandom);
        raddr[k*AW +: AW] = narrow ? 5'($urandom_range(0, 7)) : 5'($urandom);
        wdata[k*XLEN +: XLEN] = {$urandom, $urandom};
      end
      alloc_en = ($urandom_range(0, 2) != 0);
      alloc_addr = narrow ? 5'($urandom_range(0, 7)) : 5'($urandom);
      flush = ($urandom_range(0, 19) == 0);
      tick();
    end

    idle();
    rst_n = 1'b1;
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
